// File: rtl/shifter_pkg.sv
// shifter_pkg: widths and pipeline stage record for the left barrel shifter.
// SHIFTER_ROTATE_EN adds the per-stage rotate flag.
package shifter_pkg;
   localparam int DATA_W  = 32;
   localparam int SHAMT_W = 5;
   typedef struct packed {
      logic               valid;
      logic [DATA_W-1:0]  data;
      logic [SHAMT_W-1:0] shamt;
`ifdef SHIFTER_ROTATE_EN
      logic               rotate;
`endif
   } stage_t;
endpackage

// File: rtl/shift_left_stage.sv
// shift_left_stage: one registered stage shifting by 2^K when shamt bit K is set.
// SHIFTER_ROTATE_EN feeds the bits leaving the top back into the vacated low bits.
module shift_left_stage
   import shifter_pkg::*;
#(
   parameter int K = 0
) (
   input  logic   clk_i,
   input  logic   rstn_i,
   input  logic   advance_i,
   input  stage_t stage_i,
   output stage_t stage_o
);
   localparam int DIST = 1 << K;
   logic [DATA_W-1:0] w_shifted;
   stage_t            w_next;
   stage_t            r_stage;
   always_comb begin
`ifdef SHIFTER_ROTATE_EN
      w_shifted = (stage_i.data << DIST) | (stage_i.rotate ? stage_i.data >> (DATA_W - DIST) : '0);
`else
      w_shifted = stage_i.data << DIST;
`endif
      w_next      = stage_i;
      w_next.data = stage_i.shamt[K] ? w_shifted : stage_i.data;
   end
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) r_stage <= '0;
      else if (advance_i) r_stage <= w_next;
   end
   assign stage_o = r_stage;
endmodule

// File: rtl/barrel_shifter_left_pipe.sv
// barrel_shifter_left_pipe: 5-stage logarithmic left shifter with valid/ready flow control.
// SHIFTER_ROTATE_EN adds in_rotate_i for rotate-left mode.
module barrel_shifter_left_pipe #(
   parameter int DATA_W  = 32,
   parameter int SHAMT_W = 5
) (
   input  logic               clk_i,
   input  logic               rstn_i,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  logic [DATA_W-1:0]  in_data_i,
   input  logic [SHAMT_W-1:0] in_shamt_i,
`ifdef SHIFTER_ROTATE_EN
   input  logic               in_rotate_i,
`endif
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [DATA_W-1:0]  out_data_o
);
   import shifter_pkg::*;
   if (DATA_W != 32 || SHAMT_W != 5) begin : g_bad_cfg
      $error("barrel_shifter_left_pipe supports only DATA_W=32, SHAMT_W=5");
   end
   stage_t w_in;
   stage_t w_pipe [0:5];
   logic   w_advance;
   logic   w_unused_bits;
   always_comb begin
      w_in       = '0;
      w_in.valid = in_valid_i;
      w_in.data  = in_data_i;
      w_in.shamt = in_shamt_i;
`ifdef SHIFTER_ROTATE_EN
      w_in.rotate = in_rotate_i;
`endif
   end
   assign w_pipe[0] = w_in;
   // Whole pipe stalls together, so a held result never gets overwritten.
   assign w_advance = ~w_pipe[5].valid | out_ready_i;
   for (genvar k = 0; k < 5; k++) begin : g_stage
      shift_left_stage #(.K(k)) u_stage (
         .clk_i     (clk_i),
         .rstn_i    (rstn_i),
         .advance_i (w_advance),
         .stage_i   (w_pipe[k]),
         .stage_o   (w_pipe[k+1])
      );
   end
   assign in_ready_o  = w_advance;
   assign out_valid_o = w_pipe[5].valid;
   assign out_data_o  = w_pipe[5].data;
`ifdef SHIFTER_ROTATE_EN
   assign w_unused_bits = ^{w_pipe[5].shamt, w_pipe[5].rotate};
`else
   assign w_unused_bits = ^w_pipe[5].shamt;
`endif
endmodule

// File: doc/barrel_shifter_left_pipe.md
BARREL_SHIFTER_LEFT_PIPE -- requirements
Module: barrel_shifter_left_pipe

Interface
REQ-001 Parameter: DATA_W, 32, operand width; 32 is the only legal value.
REQ-002 Parameter: SHAMT_W, 5, shift-amount width; equals log2(DATA_W).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk_i  input  1  clock; all state updates on its rising edge.
REQ-005 rstn_i  input  1  asynchronous active-low reset.
REQ-006 in_valid_i  input  1  input operand valid.
REQ-007 in_ready_o  output  1  block accepts operand this cycle.
REQ-008 in_data_i  input  DATA_W  value to shift.
REQ-009 in_shamt_i  input  SHAMT_W  left-shift amount, 0..31.
REQ-010 in_rotate_i  input  1  1 = rotate left, 0 = logical shift left; present only with SHIFTER_ROTATE_EN.
REQ-011 out_valid_o  output  1  result valid.
REQ-012 out_ready_i  input  1  consumer accepts result.
REQ-013 out_data_o  output  DATA_W  shifted result.

Function
REQ-014 The block SHALL be a 5-stage pipelined logarithmic left shifter; stage k (k=0..4) shifts left by 2^k when shift-amount bit k is 1, else passes through.
REQ-015 Each stage register SHALL hold valid, data, the remaining shift-amount bits, and the rotate flag when compiled in.
REQ-016 Logical mode: vacated low bits SHALL be filled with 0; bits shifted past bit 31 are discarded.
REQ-017 Pipeline advance: advance = ~out_valid_o | out_ready_i; all stages SHALL load from their predecessor only when advance = 1, else hold.
REQ-018 in_ready_o SHALL equal advance (combinational from out_ready_i and out_valid_o).
REQ-019 Transfer in: in_valid_i & in_ready_o; stage 0 valid loads in_valid_i on advance, so bubbles propagate.
REQ-020 Transfer out: out_valid_o & out_ready_i; a result SHALL stay stable on out_data_o while out_valid_o = 1 and out_ready_i = 0.
REQ-021 Latency SHALL be exactly 5 cycles from input transfer to out_valid_o with no backpressure; throughput one operand per cycle.
REQ-022 Results SHALL leave in acceptance order; none lost or duplicated under any out_ready_i pattern.
REQ-023 in_shamt_i = 0 SHALL return in_data_i unchanged after 5 cycles.
REQ-024 Simultaneous input and output transfer in one cycle SHALL both complete.
REQ-025 out_data_o and out_valid_o SHALL be driven directly from stage-4 registers (no combinational path from inputs).

Reset
REQ-026 While rstn_i = 0, all stage valid bits SHALL be 0, data and shift-amount registers 0, out_valid_o = 0, out_data_o = 0.
REQ-027 in_ready_o SHALL be 1 during and after reset (out_valid_o = 0).
REQ-028 Reset mid-operation SHALL discard all in-flight operands immediately (asynchronous); none appear after release.

Configuration
REQ-029 Macro SHIFTER_ROTATE_EN defined: in_rotate_i exists; when 1, vacated low bits of each stage SHALL take the bits shifted out of the top (rotate left by in_shamt_i).
REQ-030 Macro SHIFTER_ROTATE_EN undefined: in_rotate_i and the rotate flag registers SHALL not exist; behaviour is logical shift left only.

Structure
REQ-031 Shared package shifter_pkg SHALL hold DATA_W, SHAMT_W, and the stage register typedef (valid, data, shamt, rotate).
REQ-032 One sub-module shift_left_stage SHALL implement one stage (parameterised by shift distance 2^k, registered, with hold on advance = 0), instantiated five times.

Verification
REQ-033 0x0000_0001, shamt 31, out_ready_i = 1 -> out_data_o 0x8000_0000, out_valid_o high exactly 5 cycles after transfer.
REQ-034 0xFFFF_FFFF shamt 4, then 0x1234_5678 shamt 0 back-to-back -> 0xFFFF_FFF0 then 0x1234_5678 on consecutive cycles.
REQ-035 Six operands back-to-back (0x1 shamt 0..5), out_ready_i = 0 from first result for 4 cycles -> in_ready_o = 0, output held at 0x1; on release 0x1,0x2,0x4,0x8,0x10,0x20 in order.
REQ-036 0x8000_0001 shamt 1: with SHIFTER_ROTATE_EN and in_rotate_i = 1 -> 0x0000_0003; in_rotate_i = 0 or macro undefined -> 0x0000_0002.
REQ-037 Three operands in flight, rstn_i pulsed low mid-cycle -> out_valid_o = 0 immediately; after release no result appears for 10 cycles with in_valid_i = 0.
